// File: rtl/flash_read_arbiter.sv
// Shares one external flash byte reader between two requesters.
// Single-byte reads, round-robin grant, hung-flash timeout.
module flash_read_arbiter #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned TIMEOUT = 32'd100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic [7:0]        data0,
    output logic              ack0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [7:0]        data1,
    output logic              ack1,
    output logic              err1,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_enable,
    input  logic [7:0]        flash_data,
    input  logic              flash_ready,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 32;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_BYTE     = DATA_W'(8'hFF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic                owner_q, owner_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data0_q, data0_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;

    logic                timeout_c;
    logic                grant_c;
    logic [DATA_W-1:0]   rd_byte_c;

    assign timeout_c = (cnt_q == TIMEOUT_LAST);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            owner_q <= 1'b1;
            busy_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        en_d      = en_q;
        owner_d   = owner_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        grant_c   = 1'b0;
        rd_byte_c = flash_ready ? flash_data : ERR_BYTE;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes next
                    grant_c = (req0 && req1) ? ~owner_q : req1;
                    owner_d = grant_c;
                    addr_d  = grant_c ? addr1 : addr0;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // flash_ready takes precedence over a coincident timeout
                if (flash_ready || timeout_c) begin
                    if (owner_q) begin
                        data1_d = rd_byte_c;
                        ack1_d  = 1'b1;
                        err1_d  = ~flash_ready;
                    end else begin
                        data0_d = rd_byte_c;
                        ack0_d  = 1'b1;
                        err0_d  = ~flash_ready;
                    end
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!flash_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data0        = data0_q;
    assign ack0         = ack0_q;
    assign err0         = err0_q;
    assign data1        = data1_q;
    assign ack1         = ack1_q;
    assign err1         = err1_q;
    assign flash_addr   = addr_q;
    assign flash_enable = en_q;
    assign busy         = busy_q;
    assign owner        = owner_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: single read, contention,
// round-robin, timeout, release handshake and reset mid-read.
module tb_flash_read_arbiter;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [7:0]        data0;
    logic              ack0;
    logic              err0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [7:0]        data1;
    logic              ack1;
    logic              err1;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_enable;
    logic [7:0]        flash_data;
    logic              flash_ready;
    logic              busy;
    logic              owner;

    int checks   = 0;
    int failures = 0;

    flash_read_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .addr0        (addr0),
        .data0        (data0),
        .ack0         (ack0),
        .err0         (err0),
        .req1         (req1),
        .addr1        (addr1),
        .data1        (data1),
        .ack1         (ack1),
        .err1         (err1),
        .flash_addr   (flash_addr),
        .flash_enable (flash_enable),
        .flash_data   (flash_data),
        .flash_ready  (flash_ready),
        .busy         (busy),
        .owner        (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash answers after n READ cycles, then drops ready once DONE is reached
    task automatic flash_respond(input logic [7:0] d, input int n);
        repeat (n) tick();
        flash_data  = d;
        flash_ready = 1'b1;
        tick();
        flash_ready = 1'b0;
    endtask

    initial begin
        logic exp_w;

        rst_n       = 1'b0;
        req0        = 1'b0;
        req1        = 1'b0;
        addr0       = '0;
        addr1       = '0;
        flash_data  = 8'h00;
        flash_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_data0",  32'(data0), 32'h0);
        check("rst_data1",  32'(data1), 32'h0);
        check("rst_ack0",   32'(ack0), 32'd0);
        check("rst_ack1",   32'(ack1), 32'd0);
        check("rst_en",     32'(flash_enable), 32'd0);
        check("rst_addr",   32'(flash_addr), 32'h0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_owner",  32'(owner), 32'd1);
        rst_n = 1'b1;

        // Single read on port 0
        req0  = 1'b1;
        addr0 = 11'h123;
        tick();
        check("t1_addr",  32'(flash_addr), 32'h123);
        check("t1_en",    32'(flash_enable), 32'd1);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_busy",  32'(busy), 32'd1);
        flash_respond(8'hA5, 2);
        check("t1_ack0",  32'(ack0), 32'd1);
        check("t1_data0", 32'(data0), 32'hA5);
        check("t1_err0",  32'(err0), 32'd0);
        check("t1_ack1",  32'(ack1), 32'd0);
        check("t1_en_done", 32'(flash_enable), 32'd0);
        req0 = 1'b0;
        tick();
        check("t1_ack0_pulse", 32'(ack0), 32'd0);
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_data0_hold", 32'(data0), 32'hA5);

        // Contention straight after reset
        rst_n = 1'b0;
        #1;
        check("t2_rst_owner", 32'(owner), 32'd1);
        check("t2_rst_data0", 32'(data0), 32'h0);
        #3;
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 11'h010;
        addr1 = 11'h020;
        tick();
        check("t2_addr0",  32'(flash_addr), 32'h010);
        check("t2_owner0", 32'(owner), 32'd0);
        flash_respond(8'h11, 1);
        check("t2_ack0",  32'(ack0), 32'd1);
        check("t2_data0", 32'(data0), 32'h11);
        check("t2_ack1_lo", 32'(ack1), 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        tick();
        check("t2_addr1",  32'(flash_addr), 32'h020);
        check("t2_owner1", 32'(owner), 32'd1);
        flash_respond(8'h22, 0);
        check("t2_ack1",  32'(ack1), 32'd1);
        check("t2_data1", 32'(data1), 32'h22);
        check("t2_ack0_lo", 32'(ack0), 32'd0);
        check("t2_data0_hold", 32'(data0), 32'h11);

        // Round-robin with both requesters always asking
        req0 = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_w = (i % 2 == 1);
            tick();
            check("t3_owner", 32'(owner), 32'(exp_w));
            check("t3_addr",  32'(flash_addr), exp_w ? 32'h020 : 32'h010);
            flash_respond(8'(8'h30 + i), 0);
            check("t3_ack0", 32'(ack0), 32'(!exp_w));
            check("t3_ack1", 32'(ack1), 32'(exp_w));
            check("t3_excl", 32'(ack0 & ack1), 32'd0);
            check("t3_data", exp_w ? 32'(data1) : 32'(data0), 32'(8'h30 + i));
            tick();
            tick();
        end

        // Timeout on port 1
        req0  = 1'b0;
        req1  = 1'b1;
        addr1 = 11'h3FF;
        tick();
        check("t4_owner", 32'(owner), 32'd1);
        check("t4_addr",  32'(flash_addr), 32'h3FF);
        repeat (15) tick();
        check("t4_no_ack_yet", 32'(ack1), 32'd0);
        check("t4_en_still",   32'(flash_enable), 32'd1);
        tick();
        check("t4_ack1",  32'(ack1), 32'd1);
        check("t4_err1",  32'(err1), 32'd1);
        check("t4_data1", 32'(data1), 32'hFF);
        check("t4_err0",  32'(err0), 32'd0);
        check("t4_en_lo", 32'(flash_enable), 32'd0);
        req1 = 1'b0;
        tick();
        check("t4_err1_pulse", 32'(err1), 32'd0);
        tick();
        check("t4_idle", 32'(busy), 32'd0);

        // Release handshake: ready held high after DONE
        req0  = 1'b1;
        addr0 = 11'h055;
        tick();
        check("t5_owner", 32'(owner), 32'd0);
        flash_data  = 8'h5A;
        flash_ready = 1'b1;
        tick();
        check("t5_ack0",  32'(ack0), 32'd1);
        check("t5_data0", 32'(data0), 32'h5A);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_hold_en",   32'(flash_enable), 32'd0);
            check("t5_hold_busy", 32'(busy), 32'd1);
        end
        flash_ready = 1'b0;
        tick();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_en",   32'(flash_enable), 32'd0);
        tick();
        check("t5_regrant_en",   32'(flash_enable), 32'd1);
        check("t5_regrant_addr", 32'(flash_addr), 32'h055);

        // Reset while in READ
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_en_async",  32'(flash_enable), 32'd0);
        check("t6_busy",      32'(busy), 32'd0);
        check("t6_owner",     32'(owner), 32'd1);
        check("t6_data0",     32'(data0), 32'h0);
        req0 = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_ack0", 32'(ack0), 32'd0);
            check("t6_no_ack1", 32'(ack1), 32'd0);
            check("t6_en",      32'(flash_enable), 32'd0);
            check("t6_addr",    32'(flash_addr), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
